// File: rtl/sincos_pkg.sv
// Shared definitions for the sine/cosine scheduler.
//   W          : angle/result width (signed Q18.8)
//   *_PI_Q     : pi-related constants in Q18.8
//   ID_W       : tag id width, sized for the largest supported requester count (8)
//   op_e       : requested function (sine or cosine)
//   tag_t      : in-flight tag entry {valid, id}
package sincos_pkg;

  localparam int W         = 27;
  localparam int ID_W      = 3;
  localparam int HALF_PI_Q = 402;
  localparam int PI_Q      = 804;
  localparam int TWO_PI_Q  = 1608;

  typedef enum logic {
    OP_SIN = 1'b0,
    OP_COS = 1'b1
  } op_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
//   clk, rst      : clock, asynchronous active-low reset
//   i_req         : request vector
//   i_advance     : a grant was consumed this cycle; move pointer past it
//   o_grant       : one-hot grant (zero when no request)
//   o_grant_idx   : encoded index of the granted requester
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic             w_found;

  // Search upward from the pointer, wrapping, and take the first request.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_found                                 = 1'b1;
        o_grant[(int'(r_ptr) + k) % NUM_REQ]    = 1'b1;
        o_grant_idx = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (o_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : o_grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sin_sched.sv
// Shares one fixed-latency sine pipeline among NUM_REQ requesters.
// Cosine requests are issued as sin(angle + pi/2), wrapped into [-pi, pi].
// A tag shift register, matched to the pipeline latency, routes each
// result back to the requester that issued it.
//   clk, rst    : clock, asynchronous active-low reset
//   req_valid   : per-requester request valid
//   req_ready   : per-requester grant (combinational, one-hot or zero)
//   req_op      : per-requester op (0 = sin, 1 = cos)
//   req_angle   : packed angles, requester i at [i*W +: W]
//   sin_en      : enable to the sine pipeline
//   sin_angle   : registered angle to the sine pipeline
//   sin_result  : sine pipeline output
//   rsp_valid   : one-hot single-cycle result strobe
//   rsp_data    : result data shared by all requesters
//   busy        : any tag in flight or any request pending
module sin_sched #(
  parameter int NUM_REQ     = 4,
  parameter int W           = sincos_pkg::W,
  parameter int SIN_LATENCY = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ-1:0]   req_op,
  input  logic [NUM_REQ*W-1:0] req_angle,
  output logic                 sin_en,
  output logic [W-1:0]         sin_angle,
  input  logic [W-1:0]         sin_result,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [W-1:0]         rsp_data,
  output logic                 busy
);

  import sincos_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int LAST  = SIN_LATENCY;

  logic                 r_sin_en;
  logic [W-1:0]         r_sin_angle;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [W-1:0]         r_rsp_data;
  tag_t                 r_tags [LAST+1];

  logic [NUM_REQ-1:0]   w_grant;
  logic [IDX_W-1:0]     w_grant_idx;
  logic                 w_hs;
  logic [W-1:0]         w_angle;
  logic signed [W:0]    w_cos_sum;
  logic [W-1:0]         w_issue_angle;
  logic                 w_busy;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_req       (req_valid),
    .i_advance   (w_hs),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  // No grants until the pipeline enable is up (reset and the first cycle after it).
  assign req_ready = w_grant & {NUM_REQ{r_sin_en}};
  assign w_hs      = |(req_valid & req_ready);

  // Cosine becomes sine of a quarter-turn-advanced angle; one extra bit keeps the
  // sum exact before it is folded back into range.
  always_comb begin
    w_angle   = req_angle[w_grant_idx*W +: W];
    w_cos_sum = $signed({w_angle[W-1], w_angle}) + $signed((W+1)'(HALF_PI_Q));
    if (w_cos_sum > $signed((W+1)'(PI_Q))) begin
      w_cos_sum = w_cos_sum - $signed((W+1)'(TWO_PI_Q));
    end
    w_issue_angle = (op_e'(req_op[w_grant_idx]) == OP_COS) ? w_cos_sum[W-1:0] : w_angle;
  end

  always_comb begin
    w_busy = |req_valid;
    for (int s = 0; s <= LAST; s++) begin
      w_busy = w_busy | r_tags[s].valid;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sin_en    <= 1'b0;
      r_sin_angle <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      // NOTE: the tag entries are reset because their valid bits decide whether a
      // result is reported; the sine pipeline data is left alone, since stale
      // values there can never be matched to a cleared tag.
      for (int s = 0; s <= LAST; s++) begin
        r_tags[s] <= '0;
      end
    end else begin
      r_sin_en <= 1'b1;
      if (w_hs) begin
        r_sin_angle <= w_issue_angle;
      end
      r_tags[0] <= '{valid: w_hs, id: ID_W'(w_grant_idx)};
      for (int s = 1; s <= LAST; s++) begin
        r_tags[s] <= r_tags[s-1];
      end
      if (r_tags[LAST].valid) begin
        r_rsp_valid <= NUM_REQ'(1) << r_tags[LAST].id;
        r_rsp_data  <= sin_result;
      end else begin
        r_rsp_valid <= '0;
      end
    end
  end

  assign sin_en    = r_sin_en;
  assign sin_angle = r_sin_angle;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = w_busy;

endmodule

// File: tb/tb_sin_sched.sv
module tb_sin_sched;

  localparam int NUM_REQ = 4;
  localparam int W       = 27;
  localparam int LAT     = 20;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   req_op;
  logic [NUM_REQ*W-1:0] req_angle;
  logic                 sin_en;
  logic [W-1:0]         sin_angle;
  logic [W-1:0]         sin_result;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [W-1:0]         rsp_data;
  logic                 busy;

  sin_sched #(.NUM_REQ(NUM_REQ), .W(W), .SIN_LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_angle  (req_angle),
    .sin_en     (sin_en),
    .sin_angle  (sin_angle),
    .sin_result (sin_result),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Golden sine of a Q18.8 angle, result in Q18.8.
  function automatic logic [W-1:0] sin_f(input logic signed [W-1:0] a);
    real r;
    r = $sin($itor(a) / 256.0) * 256.0;
    return W'($rtoi(r));
  endfunction

  // Phase adjustment for cosine requests.
  function automatic int adj(input bit op, input int a);
    int x;
    x = a;
    if (op) begin
      x = x + 402;
      if (x > 804) x = x - 1608;
    end
    return x;
  endfunction

  // Sine pipeline model: free-running delay line, never reset or stalled.
  logic [W-1:0] sm_pipe [LAT];
  always @(posedge clk) begin
    sm_pipe[0] <= sin_f(sin_angle);
    for (int i = 1; i < LAT; i++) sm_pipe[i] <= sm_pipe[i-1];
  end
  assign sin_result = sm_pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int           id;
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   rsp_cnt [NUM_REQ];
  int   rsp_total = 0;
  bit   sb_en = 1'b1;
  logic [W-1:0] sa_exp = '0;
  int   last_due = 0;

  initial for (int i = 0; i < NUM_REQ; i++) rsp_cnt[i] = 0;

  // Monitor: pop and compare whenever a response strobe appears.
  always @(negedge clk) begin
    exp_t e;
    if (rst && rsp_valid != '0) begin
      rsp_total++;
      for (int i = 0; i < NUM_REQ; i++) if (rsp_valid[i]) rsp_cnt[i]++;
      if (sb.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_valid), 64'(0));
      end else begin
        e = sb.pop_front();
        check("rsp_id", 64'(rsp_valid), 64'(1) << e.id);
        check("rsp_data", 64'(rsp_data), 64'(e.data));
        check("rsp_cycle", 64'(cyc), 64'(e.due));
      end
    end
    if (sb.size() > 0 && cyc > sb[0].due) begin
      e = sb.pop_front();
      check("rsp_timeout", 64'(cyc), 64'(e.due));
    end
  end

  // One cycle of stimulus. g = expected grant index (-1 for none); exp_sa = expected
  // sin_angle for the granted request.
  task automatic step(input logic [3:0] v, input logic [3:0] op,
                      input int a0, input int a1, input int a2, input int a3,
                      input int g, input int exp_sa);
    exp_t e;
    @(posedge clk); #1;
    check("sin_angle", 64'(sin_angle), 64'(sa_exp));
    req_valid = v;
    req_op    = op;
    req_angle = {W'(a3), W'(a2), W'(a1), W'(a0)};
    @(negedge clk);
    check("req_ready", 64'(req_ready), (g >= 0) ? (64'(1) << g) : 64'(0));
    if (g >= 0) begin
      sa_exp = W'(exp_sa);
      if (sb_en) begin
        e.id   = g;
        e.data = sin_f(W'(exp_sa));
        e.due  = cyc + LAT + 2;
        sb.push_back(e);
        last_due = e.due;
      end
    end
  endtask

  task automatic idle();
    step(4'b0000, 4'b0000, 0, 0, 0, 0, -1, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain", 64'(sb.size()), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    check({tag, "_sin_en"},    64'(sin_en),    64'(0));
    check({tag, "_sin_angle"}, 64'(sin_angle), 64'(0));
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    check({tag, "_rsp_data"},  64'(rsp_data),  64'(0));
    check({tag, "_busy"},      64'(busy),      64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base [NUM_REQ];
    int tot0;
    int n;
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_angle = '0;
    #1 rst = 1'b0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // ---- release; no grant in the first cycle; single sin from requester 2 ----
    @(posedge clk); #1;
    rst       = 1'b1;
    req_valid = 4'b0100;
    req_angle = {W'(0), W'(201), W'(0), W'(0)};
    @(negedge clk);
    check("first_cycle_sin_en", 64'(sin_en), 64'(0));
    check("first_cycle_ready", 64'(req_ready), 64'(0));
    step(4'b0100, 4'b0000, 0, 0, 201, 0, 2, 201);
    check("sin_en_up", 64'(sin_en), 64'(1));
    idle();
    drain();

    // ---- cosine conversion, wrap and boundaries (pointer at 3) ----
    step(4'b0001, 4'b0001,  700, 0, 0, 0, 0, -506);
    step(4'b0001, 4'b0001, -804, 0, 0, 0, 0, -402);
    step(4'b0001, 4'b0001,  402, 0, 0, 0, 0,  804);
    step(4'b0001, 4'b0001,  403, 0, 0, 0, 0, -803);
    step(4'b0001, 4'b0001,    0, 0, 0, 0, 0,  402);
    step(4'b0001, 4'b0000, -300, 0, 0, 0, 0, -300);
    idle();
    drain();

    // ---- fairness: bring pointer to 0, then all four requesting ----
    for (int i = 0; i < NUM_REQ; i++) base[i] = rsp_cnt[i];
    step(4'b1000, 4'b0000, 0, 0, 0, 50, 3, 50);
    for (int k = 0; k < 8; k++) begin
      int ang [NUM_REQ];
      for (int i = 0; i < NUM_REQ; i++) ang[i] = 100 * i + 10 * k - 150;
      step(4'b1111, 4'b0000, ang[0], ang[1], ang[2], ang[3], k % 4, ang[k % 4]);
    end
    idle();
    drain();
    for (int i = 0; i < NUM_REQ; i++)
      check("fair_count", 64'(rsp_cnt[i] - base[i]), (i == 3) ? 64'(3) : 64'(2));

    // ---- sparse: requester 1 every third cycle ----
    for (int j = 0; j < 4; j++) begin
      step(4'b0010, 4'b0000, 0, 64 * j - 100, 0, 0, 1, 64 * j - 100);
      idle();
      idle();
    end
    n = 0;
    while (cyc < last_due - 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy_before_last", 64'(busy), 64'(1));
    while (cyc < last_due + 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy_after_last", 64'(busy), 64'(0));
    drain();

    // ---- reset mid-flight ----
    sb_en = 1'b0;
    for (int j = 0; j < 5; j++) step(4'b0100, 4'b0000, 0, 0, 11 * j, 0, 2, 11 * j);
    for (int j = 0; j < 5; j++) idle();
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sa_exp = '0;
    sb_en  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tot0 = rsp_total;
    repeat (30) @(negedge clk);
    check("no_stale_rsp", 64'(rsp_total - tot0), 64'(0));
    step(4'b0010, 4'b0000, 0, 100, 0, 0, 1, 100);
    idle();
    drain();

    // ---- back-to-back mixed ops on requesters 0 and 3 (pointer at 2) ----
    for (int k = 0; k < 16; k++) begin
      int a0, a3, g;
      logic [3:0] op;
      a0 = -804 + 100 * k;
      a3 = 804 - 101 * k;
      op = (k & 2) ? 4'b0001 : 4'b1000;
      g  = (k % 2 == 0) ? 3 : 0;
      step(4'b1001, op, a0, 0, 0, a3, g, (g == 3) ? adj(op[3], a3) : adj(op[0], a0));
    end
    idle();
    drain();

    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sin_sched.md
Name: sin_sched

Overview:
- Shares one fixed-latency sine pipeline (`sin`) among NUM_REQ requesters.
- Arbitrates requests round-robin and issues at most one angle per cycle.
- Converts cosine requests into phase-shifted sine requests.
- Tracks in-flight requests with a tag shift register and returns each result to the requester that issued it.
- Sits between the t_block compute units and the `sin` instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- W, 27, angle/result width; signed fixed point Q18.8.
- SIN_LATENCY, 20, cycles from sin_angle sampled to the matching sin_result valid on the sin output.
- HALF_PI_Q, 402, pi/2 in Q18.8.
- PI_Q, 804, pi in Q18.8.
- TWO_PI_Q, 1608, 2*pi in Q18.8.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant (combinational, one-hot or zero)
- req_op  in  NUM_REQ  per-requester op: 0 = sin, 1 = cos
- req_angle  in  NUM_REQ*W  packed angles, requester i at bits [i*W +: W]
- sin_en  out  1  enable to the `sin` pipeline
- sin_angle  out  W  registered angle to the `sin` pipeline
- sin_result  in  W  `sin` pipeline output
- rsp_valid  out  NUM_REQ  one-hot result strobe, single cycle
- rsp_data  out  W  result, shared by all requesters
- busy  out  1  high while any tag is in flight or an issue is pending

Behaviour:
- Reset (rst low, asynchronous):
  - req_ready=0, sin_en=0, sin_angle=0, rsp_valid=0, rsp_data=0, busy=0.
  - All tag valid bits cleared; round-robin pointer = 0.
  - Pipeline contents are not cleared. Cleared tags guarantee stale results are never reported.
- sin_en: registered 1 from the first clk edge after rst deasserts; held 1 thereafter.
  - The `sin` pipeline contains un-gated delay registers, so it is never stalled.
- No backpressure on responses. Requesters must accept rsp_valid in the cycle it is asserted.
- Arbitration (combinational):
  - Grant the first asserted req_valid at or after the pointer, searching upward with wrap.
  - req_ready[g]=1 for that index only; handshake = req_valid[g] & req_ready[g].
  - After a handshake, pointer <= (g+1) mod NUM_REQ. No handshake leaves the pointer unchanged.
  - No grant during reset or in the first cycle after reset deassertion (sin_en still 0).
- Issue stage (registered at the handshake edge):
  - req_op=0: sin_angle <= angle.
  - req_op=1: a = angle + HALF_PI_Q, computed at W+1 bits. If a > PI_Q then a -= TWO_PI_Q. sin_angle <= a[W-1:0].
  - Input range is [-PI_Q, PI_Q]; out-of-range input gives an unspecified value but is still tagged and returned.
  - With no handshake, sin_angle holds its value and no tag is inserted.
- Tag pipe:
  - Depth SIN_LATENCY+1, entries {valid, id[$clog2(NUM_REQ)-1:0]}.
  - Stage 0 is loaded at the same edge as sin_angle and shifts every cycle.
  - When the last stage is valid: rsp_data <= sin_result and rsp_valid <= onehot(id) at the next edge; otherwise rsp_valid <= 0 and rsp_data holds.
- Latency: handshake in cycle t gives rsp_valid in cycle t+SIN_LATENCY+2. Throughput is 1 per cycle.
- Ordering: responses return in issue order; the id carried in the tag selects the destination requester.
- busy = any tag valid OR any req_valid.
- Reset mid-operation drops all in-flight requests; no response is ever produced for them.

Decomposition:
- Package `sincos_pkg`: W, the Q18.8 constants (HALF_PI_Q, PI_Q, TWO_PI_Q), the tag struct {valid, id}, and an `op_e` enum (OP_SIN, OP_COS).
- Sub-module `rr_arbiter` (NUM_REQ): req vector, advance strobe -> one-hot grant plus encoded index; owns the pointer.
- The tag shift register stays inline.

Test Plan:
- Single sin: requester 2 sends angle 201 (pi/4), op=0 -> sin_angle=201 one cycle later; rsp_valid=4'b0100 at t+22; rsp_data equals the golden `sin` model output for 201.
- Cos wrap: requester 0 sends angle 700, op=1 -> sin_angle=-506 (700+402-1608). Angle -804, op=1 -> sin_angle=-402.
- Fairness: all 4 requesters hold valid for 8 cycles with pointer=0 -> grants in order 0,1,2,3,0,1,2,3; each requester gets exactly 2 responses; rsp_valid ids follow the same order in back-to-back cycles.
- Sparse/idle: requests from requester 1 only, every 3rd cycle -> grant every 3rd cycle; pointer returns to 2 each time, still granting 1 next; zero gaps lost; busy falls 1 cycle after the last rsp_valid.
- Reset mid-flight: issue 5 requests, assert rst at t+10 -> all outputs 0 immediately; no rsp_valid for 30 cycles after release without new requests; first post-reset request returns correctly.
- Back-to-back mixed ops: alternate op 0/1 on requesters 0 and 3 for 16 cycles -> 16 responses in issue order, each matching the golden model for its adjusted angle.
